ssd_scan_ctrl: RTL and testbench

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

---
 rtl/ssd_scan_if.sv | 26 ++
 rtl/ssd_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_if.sv
// Signal bundle between a display client and the seven-segment scan controller.
// The client side (master) drives the data and live controls; the controller drives the pins and pulses.
interface ssd_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_tick;
  logic                    load_ack;

  modport master (
    output load, value_in, dp_in, digit_en, lz_blank,
    input  an, seg, dp, frame_tick, load_ack
  );

  modport slave (
    input  load, value_in, dp_in, digit_en, lz_blank,
    output an, seg, dp, frame_tick, load_ack
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronous shadow buffering.
// Pin outputs are registered one cycle behind the scan state; load is always accepted (latest wins).
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 17,
  parameter int BLANK_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        Reset,
  ssd_scan_if.slave   bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_DIV_BITS-1:0] CNT_MAX   = '1;
  localparam logic [SCAN_DIV_BITS-1:0] BLANK_CNT = SCAN_DIV_BITS'(BLANK_CYCLES);

  logic [SCAN_DIV_BITS-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]  act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]    act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                     pend_vld_q, pend_vld_d;
  logic [NUM_DIGITS-1:0]    an_q, an_d;
  logic [6:0]               seg_q, seg_d;
  logic                     dp_q, dp_d;
  logic                     frame_tick_q, frame_tick_d;
  logic                     load_ack_q, load_ack_d;
  logic                     boundary;

  // Scan position and shadow/active buffer management
  always_comb begin
    boundary   = (cnt_q == CNT_MAX) && (idx_q == LAST_IDX);
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    if (cnt_q == CNT_MAX) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    if (boundary) begin
      if (bus.load) begin
        act_val_d = bus.value_in;
        act_dp_d  = bus.dp_in;
      end else if (pend_vld_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
      end
      pend_vld_d = 1'b0;
    end else if (bus.load) begin
      pend_val_d = bus.value_in;
      pend_dp_d  = bus.dp_in;
      pend_vld_d = 1'b1;
    end
    frame_tick_d = boundary;
    load_ack_d   = boundary && (bus.load || pend_vld_q);
  end

  logic [3:0] nib;
  logic       cur_dp, cur_en, cur_supp, zero_above, lit;
  logic [6:0] seg_dec;

  // A digit is suppressed when it and every digit to its left are zero
  always_comb begin
    nib        = 4'h0;
    cur_dp     = 1'b0;
    cur_en     = 1'b0;
    cur_supp   = 1'b0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (act_val_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        nib      = act_val_q[4*i +: 4];
        cur_dp   = act_dp_q[i];
        cur_en   = bus.digit_en[i];
        cur_supp = bus.lz_blank && zero_above && (i != 0);
      end
    end
    lit = (cnt_q >= BLANK_CNT) && cur_en && !cur_supp;

    seg_dec = 7'h7f;
    case (nib)
      4'h0: seg_dec = 7'b0000001;
      4'h1: seg_dec = 7'b1001111;
      4'h2: seg_dec = 7'b0010010;
      4'h3: seg_dec = 7'b0000110;
      4'h4: seg_dec = 7'b1001100;
      4'h5: seg_dec = 7'b0100100;
      4'h6: seg_dec = 7'b0100000;
      4'h7: seg_dec = 7'b0001111;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0000100;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b1100000;
      4'hC: seg_dec = 7'b0110001;
      4'hD: seg_dec = 7'b1000010;
      4'hE: seg_dec = 7'b0110000;
      4'hF: seg_dec = 7'b0111000;
      default: seg_dec = 7'h7f;
    endcase

    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = !(lit && (idx_q == IDX_W'(i)));
    end
    seg_d = lit ? seg_dec : 7'h7f;
    dp_d  = lit ? ~cur_dp : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_vld_q   <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7f;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
      load_ack_q   <= load_ack_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.load_ack   = load_ack_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: 4 digits, 4-cycle dwell, 1 blank cycle, 16-cycle frames.
module tb_ssd_scan_ctrl;
  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  ssd_scan_if #(.NUM_DIGITS(4)) bus ();

  ssd_scan_ctrl #(
    .NUM_DIGITS(4),
    .SCAN_DIV_BITS(2),
    .BLANK_CYCLES(1)
  ) dut (
    .clk(clk),
    .Reset(Reset),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Each lit output cycle: {an, seg, dp}; each tick/ack cycle: {frame_tick, load_ack}
  logic [11:0] exp_q[$];
  logic [1:0]  ack_q[$];

  // Stimulus-side reference state
  int          ofs;
  logic [15:0] m_act, m_pend, m_bval;
  logic [3:0]  m_dp, m_pdp, m_bdp;
  logic        m_pv, m_byp;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (ofs %0d, t=%0t)", name, got, req, ofs, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  // Three lit cycles per enabled, unsuppressed digit, in scan order 0..3
  task automatic push_frame(input logic lz, input logic [3:0] en);
    logic [3:0] lit;
    logic [3:0] nib;
    logic [3:0] a;
    logic       zab;
    zab = 1'b1;
    for (int d = 3; d >= 0; d--) begin
      nib    = m_act[4*d +: 4];
      zab    = zab && (nib == 4'h0);
      lit[d] = en[d] && !(lz && zab && d > 0);
    end
    for (int d = 0; d < 4; d++) begin
      if (lit[d]) begin
        a    = 4'hF;
        a[d] = 1'b0;
        nib  = m_act[4*d +: 4];
        repeat (3) exp_q.push_back({a, seg_of(nib), ~m_dp[d]});
      end
    end
  endtask

  task automatic cyc();
    if (ofs == 15) ack_q.push_back({1'b1, m_byp | m_pv});
    @(negedge clk);
    ofs++;
  endtask

  task automatic wait_to(input int n);
    while (ofs < n) cyc();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    if (ofs == 15) begin
      m_byp = 1'b1; m_bval = v; m_bdp = d;
    end else begin
      m_pv = 1'b1; m_pend = v; m_pdp = d;
    end
    bus.load     = 1'b1;
    bus.value_in = v;
    bus.dp_in    = d;
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic next_frame(input logic lz, input logic [3:0] en);
    wait_to(16);
    check("frame_tick_period", {15'h0, bus.frame_tick}, 16'h1);
    if (m_byp) begin
      m_act = m_bval; m_dp = m_bdp;
    end else if (m_pv) begin
      m_act = m_pend; m_dp = m_pdp;
    end
    m_pv  = 1'b0;
    m_byp = 1'b0;
    ofs   = 0;
    bus.lz_blank = lz;
    bus.digit_en = en;
    push_frame(lz, en);
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"},   {12'h0, bus.an},         16'h000F);
    check({tag, "_seg"},  {9'h0, bus.seg},         16'h007F);
    check({tag, "_dp"},   {15'h0, bus.dp},         16'h0001);
    check({tag, "_tick"}, {15'h0, bus.frame_tick}, 16'h0000);
    check({tag, "_ack"},  {15'h0, bus.load_ack},   16'h0000);
  endtask

  task automatic model_clear();
    m_act = '0; m_dp = '0; m_pend = '0; m_pdp = '0; m_pv = 1'b0;
    m_byp = 1'b0; m_bval = '0; m_bdp = '0; ofs = 0;
  endtask

  // Monitor: pops an expectation whenever the DUT lights a digit or pulses tick/ack
  always @(negedge clk) begin
    if (!Reset) begin
      if (bus.frame_tick || bus.load_ack) begin
        if (ack_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL tick_ack: got tick=%0b ack=%0b, required no pulse", bus.frame_tick, bus.load_ack);
        end else begin
          check("tick_ack", {14'h0, bus.frame_tick, bus.load_ack}, {14'h0, ack_q.pop_front()});
        end
      end
      if (bus.an != 4'hF) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL disp: got an/seg/dp %b/%b/%b, required dark", bus.an, bus.seg, bus.dp);
        end else begin
          check("disp_an_seg_dp", {4'h0, bus.an, bus.seg, bus.dp}, {4'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a load asserted: the load must be discarded
    Reset        = 1'b1;
    bus.load     = 1'b1;
    bus.value_in = 16'hBEEF;
    bus.dp_in    = 4'hF;
    bus.digit_en = 4'hF;
    bus.lz_blank = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_dark("reset");
    Reset    = 1'b0;
    bus.load = 1'b0;
    push_frame(1'b0, 4'hF);

    wait_to(2);  do_load(16'h12AF, 4'h0);
    next_frame(1'b0, 4'hF);                        // 12AF, ack

    wait_to(3);  do_load(16'h1111, 4'h0);
    wait_to(9);  do_load(16'h2222, 4'b0101);
    next_frame(1'b0, 4'hF);                        // only 2222, one ack
    next_frame(1'b0, 4'hF);                        // unchanged, no ack

    wait_to(4);  do_load(16'h0000, 4'h0);
    next_frame(1'b0, 4'hF);                        // 0000 on all digits

    wait_to(6);  do_load(16'h0040, 4'h0);
    next_frame(1'b1, 4'hF);                        // digits 3,2 dark

    wait_to(15); do_load(16'h9C30, 4'b1000);       // load on the frame boundary
    next_frame(1'b1, 4'b1101);                     // bypass, digit 1 disabled
    next_frame(1'b0, 4'hF);                        // pending stays clear

    wait_to(7);  do_load(16'h0305, 4'h0);
    next_frame(1'b1, 4'hF);                        // interior zero stays lit

    // Reset mid-frame with a pending load; assert on a dark output cycle
    wait_to(2);  do_load(16'h7777, 4'hF);
    wait_to(5);
    Reset        = 1'b1;
    bus.lz_blank = 1'b0;
    exp_q.delete();
    ack_q.delete();
    @(negedge clk);
    check_dark("midreset");
    Reset = 1'b0;
    model_clear();
    push_frame(1'b0, 4'hF);
    next_frame(1'b0, 4'hF);                        // still 0000, no ack

    wait_to(17);
    check("exp_drain", 16'(exp_q.size()), 16'h0);
    check("ack_drain", 16'(ack_q.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
